// File: rtl/serial_sub_ctrl_pkg.sv
// Shared types and constants for the bit-serial subtraction controller.
package sub_pkg;

  // Controller phases: waiting for a request, shifting bits, presenting the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  // Widest operand the controller is meant to be built for.
  localparam int SUB_MAX_WIDTH = 32;

endpackage : sub_pkg

// File: rtl/serial_sub_ctrl_if.sv
// Request/result handshake bundle between a requester and serial_sub_ctrl.
interface serial_sub_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );
endinterface : serial_sub_ctrl_if

// File: rtl/serial_sub_ctrl_bit_sub_cell.sv
// One-bit full subtractor built from two cascaded half-subtractor stages.
module bit_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic hs1_d_s;
  logic hs1_b_s;
  logic hs2_b_s;

  // First stage computes x - y, second stage subtracts the incoming borrow.
  always_comb begin
    hs1_d_s = x ^ y;
    hs1_b_s = ~x & y;
    d       = hs1_d_s ^ bin;
    hs2_b_s = ~hs1_d_s & bin;
    bout    = hs1_b_s | hs2_b_s;
  end
endmodule : bit_sub_cell

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b controller: one subtractor cell, LSB first, start/busy/done handshake.
module serial_sub_ctrl
  import sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_sub_ctrl_if.slave bus
);
  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_t       state_r;
  sub_state_t       next_state_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] diff_sh_r;
  logic [CW-1:0]    cnt_r;
  logic             borrow_r;
  logic             busy_r;
  logic             done_r;
  logic             cell_d_s;
  logic             cell_bout_s;

  bit_sub_cell u_cell (
    .x    (a_sh_r[0]),
    .y    (b_sh_r[0]),
    .bin  (borrow_r),
    .d    (cell_d_s),
    .bout (cell_bout_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: accept in IDLE, stop after the last bit, DONE lasts one cycle.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          next_state_s = RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == LAST) begin
          next_state_s = DONE;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Operand/result shifting, borrow chain and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r    <= {WIDTH{1'b0}};
      b_sh_r    <= {WIDTH{1'b0}};
      diff_sh_r <= {WIDTH{1'b0}};
      cnt_r     <= {CW{1'b0}};
      borrow_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            a_sh_r    <= bus.a;
            b_sh_r    <= bus.b;
            diff_sh_r <= {WIDTH{1'b0}};
            cnt_r     <= {CW{1'b0}};
            borrow_r  <= 1'b0;
          end
        end
        RUN: begin
          a_sh_r    <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r    <= {1'b0, b_sh_r[WIDTH-1:1]};
          diff_sh_r <= {cell_d_s, diff_sh_r[WIDTH-1:1]};
          borrow_r  <= cell_bout_s;
          // Hold at the last index so a narrow counter never wraps.
          if (cnt_r != LAST) begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Handshake flags registered from the upcoming state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (next_state_s == RUN);
      done_r <= (next_state_s == DONE);
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.diff       = diff_sh_r;
  assign bus.borrow_out = borrow_r;

endmodule : serial_sub_ctrl

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial subtraction controller that computes `a - b` for two WIDTH-bit unsigned operands, one bit per clock, LSB first. It uses a single one-bit full-subtractor cell. It sequences operand shifting and the borrow chain, and reports the result through a start/busy/done handshake. It sits beside the combinational subtractor cells as the area-minimal multi-cycle alternative to a ripple subtractor.

## Interface
Parameters:
- `WIDTH`, default 8. Operand and result width; legal range 2..32.

Ports:
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `rst_n`  in  1  Reset, asynchronous and active-low.
- `start`  in  1  Request a new subtraction; sampled only in IDLE.
- `a`  in  WIDTH  Minuend; sampled on the accepting edge only.
- `b`  in  WIDTH  Subtrahend; sampled on the accepting edge only.
- `busy`  out  1  High while in RUN.
- `done`  out  1  One-cycle pulse, high while in DONE.
- `diff`  out  WIDTH  Result `(a - b) mod 2^WIDTH`.
- `borrow_out`  out  1  Final borrow; 1 iff a < b (unsigned).

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`=1.
  - RUN → DONE when the bit counter reaches WIDTH-1.
  - DONE → IDLE unconditionally.
- Accept edge (IDLE, `start`=1):
  - Latch `a` and `b` into shift registers.
  - Clear the running borrow and the bit counter.
  - Clear the diff shift register.
- Each RUN edge:
  - Cell inputs: x = a_sh[0], y = b_sh[0], bin = borrow register.
  - Cell outputs: d = x^y^bin; bout = (~x&y) | (~(x^y)&bin).
  - d shifts into diff_sh[WIDTH-1]; diff_sh shifts right.
  - a_sh and b_sh shift right; borrow ← bout; counter increments.
- After the last RUN edge:
  - `diff` = diff_sh.
  - `borrow_out` = final borrow.
  - Both hold unchanged until the next accept edge. At that edge they clear to 0 and become invalid until the next `done`.
- `start` in RUN or DONE is ignored; no queuing.
- Changes to `a`/`b` after the accept edge have no effect.
- Counter width is $clog2(WIDTH); it never wraps past WIDTH-1 in RUN.

## Timing
- Reset (`rst_n`=0, any time, including mid-RUN): state=IDLE, `busy`=0, `done`=0, `diff`=0, `borrow_out`=0, counter=0, shift registers=0. The in-flight operation is discarded, with no `done`.
- After `rst_n` deasserts, the first rising edge with `start`=1 is accepted.
- Let the accept edge be E0:
  - `busy`=1 from after E0 through after E(WIDTH-1).
  - State=DONE after EWIDTH: `done`=1 and results valid in that cycle.
  - IDLE again after E(WIDTH+1).
- Latency from accept edge to `done` high is WIDTH cycles. Throughput is one operation per WIDTH+2 cycles.
- With `start` held high continuously, the next accept is E(WIDTH+2), the first edge in IDLE.
- `busy` and `done` are never high together. `done` is exactly one cycle wide.

## Structure
- Shared package `sub_pkg`:
  - State enum `sub_state_t` {IDLE, RUN, DONE}.
  - Constant `SUB_MAX_WIDTH` = 32.
- Sub-module `bit_sub_cell`: purely combinational one-bit full subtractor (x, y, bin → d, bout), built as two cascaded half-subtractor stages with the borrows ORed.
- Top holds the FSM, counter, three shift registers and the borrow flop.

## Test plan
- WIDTH=8, a=0x5A, b=0x1C, `start` pulse → `done` 8 cycles after accept; `diff`=0x3E, `borrow_out`=0.
- a=0x10, b=0x20 → `diff`=0xF0, `borrow_out`=1. a=0x00, b=0x01 → `diff`=0xFF, `borrow_out`=1. a=0xFF, b=0xFF → `diff`=0x00, `borrow_out`=0.
- Pulse `start` with new operands 3 cycles after accept (RUN) and again in the DONE cycle → ignored; first result unchanged; exactly one `done` pulse.
- Assert `rst_n`=0 asynchronously 4 cycles into RUN → all outputs 0 immediately, no `done`. Then release reset and run a=0x80, b=0x01 → `diff`=0x7F, `borrow_out`=0.
- Hold `start`=1 continuously with fixed operands → `done` pulses every 10 cycles. `busy` is low only in the DONE and IDLE cycles between operations.
- Randomized 1000 operations at WIDTH=2 and WIDTH=16 checked against a model of `(a-b) mod 2^WIDTH` and `a<b`.
